// File: rtl/wall_spawn_scheduler.sv
// Wall spawn scheduler: periodic height requests, clamped loads into a slot table,
// per-frame scrolling and retirement, and an indexed read port for the draw logic.
//   state  | meaning
//   S_IDLE | paused or cleared; nothing counts or scrolls
//   S_RUN  | scrolling and counting frames toward the next spawn
//   S_REQ  | waiting on the height generator
//   S_LOAD | writing the latched height into the lowest free slot
module wall_spawn_scheduler #(
    parameter int SLOTS          = 4,
    parameter int SPAWN_INTERVAL = 40,
    parameter int SCREEN_X       = 160,
    parameter int MIN_H          = 8,
    parameter int MAX_H          = 88
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       clear,
    input  logic                       frame_tick,
    output logic                       gen_req,
    input  logic                       gen_valid,
    input  logic [7:0]                 gen_height,
    input  logic [$clog2(SLOTS)-1:0]   rd_idx,
    output logic                       rd_active,
    output logic [7:0]                 rd_x,
    output logic [7:0]                 rd_h,
    output logic [3:0]                 wall_count,
    output logic                       spawn_pulse,
    output logic                       overflow
);
    localparam int IDX_W = $clog2(SLOTS);
    localparam int CNT_W = $clog2(SPAWN_INTERVAL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_INTERVAL - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_REQ, S_LOAD} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_gen_req, w_req_nxt;
    logic [7:0]         r_height;
    logic               w_latch, w_expire;

    logic [SLOTS-1:0]   r_act, w_act_nxt;
    logic [7:0]         r_x [SLOTS];
    logic [7:0]         r_h [SLOTS];
    logic [7:0]         w_x_nxt [SLOTS];
    logic [7:0]         w_h_nxt [SLOTS];
    logic               r_ovf, w_ovf_nxt;
    logic               r_pulse, w_load_ok;
    logic [3:0]         r_count, w_count_nxt;
    logic               w_free_found;
    logic [IDX_W-1:0]   w_free_idx;
    logic [7:0]         w_h_clamp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_gen_req <= 1'b0;
            r_height  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gen_req <= w_req_nxt;
            if (w_latch) r_height <= gen_height;
        end
    end

    // Expiries outside RUN still wrap the counter but are simply dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_expire    = 1'b0;
        w_req_nxt   = 1'b0;
        w_latch     = 1'b0;
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (!enable) begin
            w_state_nxt = S_IDLE;
        end else if (r_state == S_IDLE) begin
            w_state_nxt = S_RUN;
        end else begin
            if (frame_tick) begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    w_expire  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            case (r_state)
                S_RUN:  if (w_expire) w_state_nxt = S_REQ;
                S_REQ: begin
                    if (gen_valid) begin
                        w_latch     = 1'b1;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_req_nxt = 1'b1;
                    end
                end
                S_LOAD: w_state_nxt = S_RUN;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        if (r_height < 8'(MIN_H))      w_h_clamp = 8'(MIN_H);
        else if (r_height > 8'(MAX_H)) w_h_clamp = 8'(MAX_H);
        else                           w_h_clamp = r_height;
    end

    // Free search uses start-of-cycle flags so a retiring slot is not reused at once.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!r_act[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_act_nxt = r_act;
        w_x_nxt   = r_x;
        w_h_nxt   = r_h;
        w_ovf_nxt = r_ovf;
        w_load_ok = 1'b0;
        if (clear) begin
            w_act_nxt = '0;
            w_ovf_nxt = 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                w_x_nxt[i] = '0;
                w_h_nxt[i] = '0;
            end
        end else if (enable && r_state != S_IDLE) begin
            if (frame_tick) begin
                for (int i = 0; i < SLOTS; i++) begin
                    if (r_act[i]) begin
                        if (r_x[i] != 8'd0) w_x_nxt[i] = r_x[i] - 8'd1;
                        else                w_act_nxt[i] = 1'b0;
                    end
                end
            end
            if (r_state == S_LOAD) begin
                if (w_free_found) begin
                    w_act_nxt[w_free_idx] = 1'b1;
                    w_x_nxt[w_free_idx]   = 8'(SCREEN_X - 1);
                    w_h_nxt[w_free_idx]   = w_h_clamp;
                    w_load_ok             = 1'b1;
                end else begin
                    w_ovf_nxt = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_count_nxt = '0;
        for (int i = 0; i < SLOTS; i++) begin
            w_count_nxt = w_count_nxt + {3'b000, w_act_nxt[i]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_act   <= '0;
            r_ovf   <= 1'b0;
            r_pulse <= 1'b0;
            r_count <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                r_x[i] <= '0;
                r_h[i] <= '0;
            end
        end else begin
            r_act   <= w_act_nxt;
            r_x     <= w_x_nxt;
            r_h     <= w_h_nxt;
            r_ovf   <= w_ovf_nxt;
            r_pulse <= w_load_ok;
            r_count <= w_count_nxt;
        end
    end

    assign gen_req     = r_gen_req;
    assign rd_active   = r_act[rd_idx];
    assign rd_x        = r_x[rd_idx];
    assign rd_h        = r_h[rd_idx];
    assign wall_count  = r_count;
    assign spawn_pulse = r_pulse;
    assign overflow    = r_ovf;

endmodule
